// File: rtl/float_issue_pkg.sv
// Shared types for the FP issue/collect slice.
// Result word: user tag carried alongside the FP unit's 32-bit answer.
package float_issue_pkg;
    localparam int TAG_W    = 4;
    localparam int FP_WIDTH = 32;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [FP_WIDTH-1:0] data;
    } float_result_t;
endpackage

// File: rtl/float_issue_collector_if.sv
// Bundle of the operand, FP-unit and result channels.
// slave = the collector, master = whoever drives operands and the FP unit.
interface float_issue_collector_if #(
    parameter int TAG_W = float_issue_pkg::TAG_W
) ();
    logic [float_issue_pkg::FP_WIDTH-1:0] op_a;
    logic [float_issue_pkg::FP_WIDTH-1:0] op_b;
    logic [TAG_W-1:0]                     op_tag;
    logic                                 op_valid;
    logic                                 op_ready;
    logic [float_issue_pkg::FP_WIDTH-1:0] fp_in1;
    logic [float_issue_pkg::FP_WIDTH-1:0] fp_in2;
    logic                                 fp_in_valid;
    logic [float_issue_pkg::FP_WIDTH-1:0] fp_q;
    logic                                 fp_q_valid;
    logic [float_issue_pkg::FP_WIDTH-1:0] res_data;
    logic [TAG_W-1:0]                     res_tag;
    logic                                 res_valid;
    logic                                 res_ready;

    modport slave (
        input  op_a, op_b, op_tag, op_valid,
        input  fp_q, fp_q_valid, res_ready,
        output op_ready, fp_in1, fp_in2, fp_in_valid,
        output res_data, res_tag, res_valid
    );

    modport master (
        output op_a, op_b, op_tag, op_valid,
        output fp_q, fp_q_valid, res_ready,
        input  op_ready, fp_in1, fp_in2, fp_in_valid,
        input  res_data, res_tag, res_valid
    );
endinterface

// File: rtl/float_sync_fifo.sv
// Show-ahead synchronous FIFO: pop_data is the head entry whenever !empty.
// Ports: clk, rst_n, push/push_data, pop/pop_data, empty, full, count.
module float_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/float_issue_collector.sv
// Issues tagged operand pairs to a fixed-latency FP unit and buffers its results.
// Ports: clk, reset (async low), bus (operand/FP/result channels), busy, err_orphan.
module float_issue_collector
    import float_issue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = float_issue_pkg::TAG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    float_issue_collector_if.slave  bus,
    output logic                    busy,
    output logic                    err_orphan
);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int RES_W = TAG_W + FP_WIDTH;

    logic [CW-1:0]    credits;
    logic [CW-1:0]    credits_next;
    logic [CW-1:0]    inflight;
    logic             op_ready_q;
    logic             issue;
    logic             complete;
    logic             orphan;
    logic             pop;
    logic [TAG_W-1:0] head_tag;
    logic [RES_W-1:0] res_word;
    logic             res_empty;
    logic             tag_empty;
    logic             tag_full;
    logic             res_full;
    logic [CW-1:0]    tag_count;
    logic [CW-1:0]    res_count;
    logic             unused_fifo;

    assign issue    = bus.op_valid & op_ready_q;
    assign complete = bus.fp_q_valid & (inflight != '0);
    assign orphan   = bus.fp_q_valid & (inflight == '0);
    assign pop      = ~res_empty & bus.res_ready;

    assign bus.op_ready    = op_ready_q;
    assign bus.fp_in1      = bus.op_a;
    assign bus.fp_in2      = bus.op_b;
    assign bus.fp_in_valid = issue;
    assign bus.res_valid   = ~res_empty;
    assign bus.res_data    = res_word[FP_WIDTH-1:0];
    assign bus.res_tag     = res_word[FP_WIDTH +: TAG_W];

    assign busy         = (credits != CW'(DEPTH));
    assign credits_next = credits - CW'(issue) + CW'(pop);
    assign unused_fifo  = ^{tag_empty, tag_full, res_full, tag_count, res_count};

    // Tags wait here while their op is inside the FP unit (in-order unit).
    float_sync_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (issue),
        .push_data (bus.op_tag),
        .pop       (complete),
        .pop_data  (head_tag),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    float_sync_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_res_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (complete),
        .push_data ({head_tag, bus.fp_q}),
        .pop       (pop),
        .pop_data  (res_word),
        .empty     (res_empty),
        .full      (res_full),
        .count     (res_count)
    );

    // A credit is held from issue until the result leaves the buffer,
    // so neither FIFO can overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits    <= CW'(DEPTH);
            inflight   <= '0;
            op_ready_q <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            credits    <= credits_next;
            op_ready_q <= (credits_next != '0);
            inflight   <= inflight + CW'(issue) - CW'(complete);
            err_orphan <= err_orphan | orphan;
        end
    end
endmodule

// File: tb/tb_float_issue_collector.sv
// Randomized bench for float_issue_collector against a queue-based model.
// The FP unit is a 3-deep delay line computing in1 - in2 on integer-valued floats.
module tb_float_issue_collector;
    import float_issue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    logic err_orphan;

    float_issue_collector_if #(.TAG_W(TAG_W)) bus ();

    float_issue_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] i2f(input int v);
        int m;
        int p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (m[i]) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    function automatic int f2i(input logic [31:0] x);
        int e;
        int m;
        if (x[30:0] == 31'h0) return 0;
        e = int'(x[30:23]) - 127;
        m = int'({1'b1, x[22:0]});
        m = m >>> (23 - e);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return i2f(f2i(a) - f2i(b));
    endfunction

    // FP unit model, latency 3, never reset (stale beats survive a reset)
    logic [2:0]  pv = 3'b000;
    logic [31:0] pd [3];
    logic        inject = 1'b0;

    always @(posedge clk) begin
        pv    <= {pv[1:0], bus.fp_in_valid};
        pd[0] <= fsub(bus.fp_in1, bus.fp_in2);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end

    assign bus.fp_q_valid = pv[2] | inject;
    assign bus.fp_q       = inject ? 32'hDEAD_BEEF : pd[2];

    // Behavioural model: ops inside the FP unit, results waiting downstream
    float_result_t inflq [$];
    float_result_t resq [$];
    bit            err_m = 1'b0;
    bit            rdy_m = 1'b0;
    bit            m_iss;
    bit            m_pop;
    int            cred_m;
    float_result_t m_e;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_op_ready", bus.op_ready, 0);
            chk("rst_fp_in_valid", bus.fp_in_valid, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_orphan", err_orphan, 0);
            inflq.delete();
            resq.delete();
            err_m = 1'b0;
            rdy_m = 1'b0;
        end else begin
            chk("op_ready", bus.op_ready, rdy_m);
            m_iss = bus.op_valid && rdy_m;
            chk("fp_in_valid", bus.fp_in_valid, m_iss);
            if (m_iss) begin
                chk("fp_in1", bus.fp_in1, bus.op_a);
                chk("fp_in2", bus.fp_in2, bus.op_b);
            end
            chk("res_valid", bus.res_valid, resq.size() != 0);
            if (resq.size() != 0) begin
                chk("res_data", bus.res_data, resq[0].data);
                chk("res_tag", bus.res_tag, resq[0].tag);
            end
            chk("busy", busy, (inflq.size() + resq.size()) != 0);
            chk("err_orphan", err_orphan, err_m);
            m_pop = (resq.size() != 0) && bus.res_ready;
            if (m_pop) void'(resq.pop_front());
            if (bus.fp_q_valid) begin
                if (inflq.size() != 0) resq.push_back(inflq.pop_front());
                else err_m = 1'b1;
            end
            if (m_iss) begin
                m_e.tag  = bus.op_tag;
                m_e.data = fsub(bus.op_a, bus.op_b);
                inflq.push_back(m_e);
            end
            cred_m = DEPTH - inflq.size() - resq.size();
            rdy_m  = (cred_m != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.op_valid = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] tag, input int av, input int bv);
        bus.op_valid = 1'b1;
        bus.op_tag   = tag;
        bus.op_a     = i2f(av);
        bus.op_b     = i2f(bv);
    endtask

    function automatic int rint();
        return int'($urandom_range(0, 1000)) - 500;
    endfunction

    int k;
    int accepted;
    int guard;

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_tag    = '0;
        bus.res_ready = 1'b0;

        // model pins
        chk("pin_i2f_3", i2f(3), 32'h4040_0000);
        chk("pin_i2f_1", i2f(1), 32'h3F80_0000);
        chk("pin_sub_3_1", fsub(32'h4040_0000, 32'h3F80_0000), 32'h4000_0000);

        repeat (3) step();
        chk("reset_busy", busy, 0);
        reset = 1'b1;
        chk("release_op_ready_low", bus.op_ready, 0);
        step();
        chk("release_op_ready_high", bus.op_ready, 1);

        // 1: single op, 4-cycle result latency
        set_op(4'd5, 3, 1);
        bus.res_ready = 1'b1;
        step();
        idle();
        k = 1;
        while (!bus.res_valid && k < 20) begin
            step();
            k++;
        end
        chk("t1_latency", k, 4);
        chk("t1_res_data", bus.res_data, 32'h4000_0000);
        chk("t1_res_tag", bus.res_tag, 5);
        step();
        chk("t1_busy_low", busy, 0);

        // 2: fill all credits with the consumer stalled
        bus.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_op(4'(i), rint(), rint());
            chk("t2_op_ready", bus.op_ready, 1);
            step();
        end
        idle();
        chk("t2_full_op_ready", bus.op_ready, 0);
        repeat (5) step();
        chk("t2_still_full", bus.op_ready, 0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_res_valid", bus.res_valid, 1);
            chk("t2_tag_order", bus.res_tag, i);
            step();
        end
        chk("t2_op_ready_back", bus.op_ready, 1);
        chk("t2_drained", bus.res_valid, 0);

        // 3: continuous streaming never stalls
        bus.res_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_op(4'($urandom), rint(), rint());
            chk("t3_no_stall", bus.op_ready, 1);
            step();
        end
        idle();
        repeat (8) step();
        chk("t3_busy_low", busy, 0);

        // 6: issue and pop together at one remaining credit
        bus.res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_op(4'(i), rint(), rint());
            step();
        end
        idle();
        repeat (6) step();
        chk("t6_pre_op_ready", bus.op_ready, 1);
        chk("t6_pre_res_valid", bus.res_valid, 1);
        set_op(4'd9, rint(), rint());
        bus.res_ready = 1'b1;
        step();
        idle();
        bus.res_ready = 1'b0;
        chk("t6_op_ready_kept", bus.op_ready, 1);
        step();
        chk("t6_op_ready_kept2", bus.op_ready, 1);
        bus.res_ready = 1'b1;
        repeat (12) step();
        chk("t6_busy_low", busy, 0);

        // 4: random traffic
        accepted = 0;
        guard = 0;
        while (accepted < 1000 && guard < 20000) begin
            if ($urandom_range(0, 9) < 7) set_op(4'($urandom), rint(), rint());
            else idle();
            bus.res_ready = 1'($urandom_range(0, 1));
            if (bus.op_valid && bus.op_ready) accepted++;
            step();
            guard++;
        end
        chk("t4_accepted", accepted, 1000);
        idle();
        bus.res_ready = 1'b1;
        repeat (15) step();
        chk("t4_busy_low", busy, 0);
        chk("t4_model_empty", inflq.size() + resq.size(), 0);

        // 5: reset mid-operation, then stale and injected beats
        bus.res_ready = 1'b0;
        set_op(4'd1, rint(), rint());
        step();
        set_op(4'd2, rint(), rint());
        step();
        idle();
        repeat (2) step();
        set_op(4'd3, rint(), rint());
        step();
        set_op(4'd4, rint(), rint());
        step();
        set_op(4'd5, rint(), rint());
        step();
        idle();
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_res_valid", bus.res_valid, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_op_ready", bus.op_ready, 0);
        chk("t5_rst_res_valid", bus.res_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_err", err_orphan, 0);
        step();
        step();
        reset = 1'b1;
        step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        chk("t5_err_orphan", err_orphan, 1);
        chk("t5_res_valid", bus.res_valid, 0);
        repeat (3) step();
        chk("t5_err_sticky", err_orphan, 1);
        chk("t5_res_still_empty", bus.res_valid, 0);
        chk("t5_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
